// File: rtl/apb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// apb_cmd_sequencer
// Upstream command stage for apb_top. Host read/write requests are queued in
// a small FIFO and replayed one at a time onto apb_top's level-driven command
// inputs. The sequencer waits for apb_top's ready, captures read data and
// returns it on a valid/ready response port. An issue that sees no ready
// within TIMEOUT cycles is aborted.
//
// Ports:
//   pclk, preset               clock, async active-high reset
//   cmd_valid_i/cmd_ready_o    host command handshake
//   cmd_write_i, cmd_wdata_i   command type (1 = write) and write data
//   add_o, wdata_o             to apb_top add_i / external_wdata_i
//                              (2'b00 idle, 2'b01 read, 2'b11 write)
//   ready_i, rdata_i           from apb_top ready_o / rdata_o
//   rsp_valid_o/rsp_ready_i    read response handshake
//   rsp_data_o, rsp_err_o      read data, timeout-abort flag
//   timeout_o                  one-cycle pulse on any aborted command
//   busy_o                     FSM active or commands queued
//   fifo_count_o               FIFO occupancy
//
// state  | meaning
// IDLE   | no command in flight; pops the FIFO head when one is queued
// ISSUE  | command driven on add_o/wdata_o, waiting for ready_i or timeout
// RDWAIT | read accepted; rdata_i settles this cycle
// RESP   | read response presented, waiting for host acceptance
// ---------------------------------------------------------------------------
module apb_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       cmd_valid_i,
    input  logic                       cmd_write_i,
    input  logic [31:0]                cmd_wdata_i,
    output logic                       cmd_ready_o,
    output logic [1:0]                 add_o,
    output logic [31:0]                wdata_o,
    input  logic                       ready_i,
    input  logic [31:0]                rdata_i,
    output logic                       rsp_valid_o,
    output logic [31:0]                rsp_data_o,
    output logic                       rsp_err_o,
    input  logic                       rsp_ready_i,
    output logic                       timeout_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Down-counter start value; the abort fires when it reaches zero, which
    // is the TIMEOUT-th cycle spent in ISSUE.
    localparam logic [TW-1:0] TO_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        state;
    logic [32:0]   mem [DEPTH];
    logic [32:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          cur_write;
    logic [TW-1:0] to_cnt;

    // Readiness comes only from the registered count, so a full FIFO never
    // reuses the slot freed by a same-cycle pop.
    assign cmd_ready_o  = (count != CW'(DEPTH));
    assign push         = cmd_valid_i && cmd_ready_o;
    // Pop also uses the registered count: no bypass of an empty FIFO.
    assign pop          = (state == S_IDLE) && (count != '0);
    assign head         = mem[rd_ptr];
    assign fifo_count_o = count;
    assign busy_o       = (state != S_IDLE) || (count != '0);

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_write_i, cmd_wdata_i};
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= S_IDLE;
            add_o       <= 2'b00;
            wdata_o     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            timeout_o   <= 1'b0;
            cur_write   <= 1'b0;
            to_cnt      <= '0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_write <= head[32];
                        add_o     <= head[32] ? 2'b11 : 2'b01;
                        wdata_o   <= head[31:0];
                        to_cnt    <= TO_LOAD;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ready_i) begin
                        add_o <= 2'b00;
                        state <= cur_write ? S_IDLE : S_RDWAIT;
                    end else if ((TIMEOUT != 0) && (to_cnt == '0)) begin
                        add_o     <= 2'b00;
                        timeout_o <= 1'b1;
                        if (cur_write) begin
                            state <= S_IDLE;
                        end else begin
                            rsp_data_o  <= '0;
                            rsp_err_o   <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            state       <= S_RESP;
                        end
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                S_RDWAIT: begin
                    rsp_data_o  <= rdata_i;
                    rsp_err_o   <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for apb_cmd_sequencer: a table of per-cycle vectors for the basic
// write/read flow, followed by hand-written sequences for FIFO full, timeout,
// response back-pressure and asynchronous reset mid-transaction.
// ---------------------------------------------------------------------------
module tb_apb_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_wdata_i = '0;
    logic        cmd_ready_o;
    logic [1:0]  add_o;
    logic [31:0] wdata_o;
    logic        ready_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        rsp_ready_i = 1'b0;
    logic        timeout_o;
    logic        busy_o;
    logic [2:0]  fifo_count_o;

    int checks = 0;
    int failures = 0;

    apb_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .pclk         (pclk),
        .preset       (preset),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_write_i  (cmd_write_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .cmd_ready_o  (cmd_ready_o),
        .add_o        (add_o),
        .wdata_o      (wdata_o),
        .ready_i      (ready_i),
        .rdata_i      (rdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_ready_i  (rsp_ready_i),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        cv;
        logic        cw;
        logic [31:0] cd;
        logic        rdy;
        logic [31:0] rdat;
        logic        rspr;
        logic [1:0]  e_add;
        logic [31:0] e_wd;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_to;
        logic        e_cr;
        logic [2:0]  e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // inputs applied before an edge | outputs expected after it
        vecs[0] = '{1'b1, 1'b1, 32'h1234ABCD, 1'b0, 32'h0, 1'b0,
                    2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0,
                    2'b11, 32'h1234ABCD, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0, 1'b0,
                    2'b00, 32'h1234ABCD, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h00000055, 1'b0, 32'h0, 1'b0,
                    2'b00, 32'h1234ABCD, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0,
                    2'b01, 32'h00000055, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0, 1'b0,
                    2'b00, 32'h00000055, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0,
                    2'b00, 32'h00000055, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1,
                    2'b00, 32'h00000055, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0,
                    2'b00, 32'h00000055, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};

        // Reset state
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_add", 32'(add_o), 32'h0);
        chk("rst_count", 32'(fifo_count_o), 32'h0);
        preset = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'h1);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_rsp_data", rsp_data_o, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);

        // Basic write then read flow
        for (int i = 0; i < 9; i++) begin
            cmd_valid_i = vecs[i].cv;
            cmd_write_i = vecs[i].cw;
            cmd_wdata_i = vecs[i].cd;
            ready_i     = vecs[i].rdy;
            rdata_i     = vecs[i].rdat;
            rsp_ready_i = vecs[i].rspr;
            tick();
            chk($sformatf("v%0d_add", i), 32'(add_o), 32'(vecs[i].e_add));
            chk($sformatf("v%0d_wdata", i), wdata_o, vecs[i].e_wd);
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid_o), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_rsp_data", i), rsp_data_o, vecs[i].e_rd);
            chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err_o), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_timeout", i), 32'(timeout_o), 32'(vecs[i].e_to));
            chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready_o), 32'(vecs[i].e_cr));
            chk($sformatf("v%0d_count", i), 32'(fifo_count_o), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        rdata_i = '0;

        // FIFO full: 5 writes pushed, first one in flight, 4 queued
        cmd_write_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cmd_valid_i = 1'b1;
            cmd_wdata_i = 32'hA0000000 | 32'(k);
            tick();
        end
        chk("full_count", 32'(fifo_count_o), 32'd4);
        chk("full_cmd_ready", 32'(cmd_ready_o), 32'h0);
        chk("full_c1_add", 32'(add_o), 32'h3);
        chk("full_c1_wdata", wdata_o, 32'hA0000001);
        cmd_wdata_i = 32'h00000BAD;
        ready_i = 1'b1;
        tick();
        chk("full_c1_done_add", 32'(add_o), 32'h0);
        chk("full_no_push_count", 32'(fifo_count_o), 32'd4);
        ready_i = 1'b0;
        tick();
        chk("full_pop_no_reuse_count", 32'(fifo_count_o), 32'd3);
        chk("full_pop_cmd_ready", 32'(cmd_ready_o), 32'h1);
        cmd_valid_i = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            n = 0;
            while (add_o == 2'b00 && n < 4) begin
                tick();
                n++;
            end
            chk($sformatf("order_c%0d_add", k), 32'(add_o), 32'h3);
            chk($sformatf("order_c%0d_wdata", k), wdata_o, 32'hA0000000 | 32'(k));
            ready_i = 1'b1;
            tick();
            chk($sformatf("order_c%0d_gap", k), 32'(add_o), 32'h0);
            ready_i = 1'b0;
        end
        tick();
        chk("full_drain_count", 32'(fifo_count_o), 32'h0);
        chk("full_drain_busy", 32'(busy_o), 32'h0);
        chk("full_drain_add", 32'(add_o), 32'h0);

        // Read timeout
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_wdata_i = 32'h00000099;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        chk("to_issue_add", 32'(add_o), 32'h1);
        n = 0;
        while (add_o == 2'b01 && n < 40) begin
            tick();
            n++;
            if (add_o == 2'b01) chk("to_early_pulse", 32'(timeout_o), 32'h0);
        end
        chk("to_issue_cycles", 32'(n), 32'(TIMEOUT));
        chk("to_pulse", 32'(timeout_o), 32'h1);
        chk("to_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("to_rsp_err", 32'(rsp_err_o), 32'h1);
        chk("to_rsp_data", rsp_data_o, 32'h0);
        tick();
        chk("to_pulse_end", 32'(timeout_o), 32'h0);
        chk("to_rsp_hold", 32'(rsp_valid_o), 32'h1);
        rsp_ready_i = 1'b1;
        tick();
        chk("to_rsp_done_valid", 32'(rsp_valid_o), 32'h0);
        chk("to_rsp_done_err", 32'(rsp_err_o), 32'h0);
        rsp_ready_i = 1'b0;

        // Response back-pressure with a write queued behind it
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_wdata_i = 32'h0;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        chk("bp_read_add", 32'(add_o), 32'h1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        rdata_i = 32'hCAFEF00D;
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_wdata_i = 32'h00000077;
        tick();
        cmd_valid_i = 1'b0;
        rdata_i = 32'h0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_valid", c), 32'(rsp_valid_o), 32'h1);
            chk($sformatf("bp%0d_data", c), rsp_data_o, 32'hCAFEF00D);
            chk($sformatf("bp%0d_err", c), 32'(rsp_err_o), 32'h0);
            chk($sformatf("bp%0d_add", c), 32'(add_o), 32'h0);
            chk($sformatf("bp%0d_count", c), 32'(fifo_count_o), 32'h1);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("bp_done_valid", 32'(rsp_valid_o), 32'h0);
        chk("bp_data_retained", rsp_data_o, 32'hCAFEF00D);
        tick();
        chk("bp_write_add", 32'(add_o), 32'h3);
        chk("bp_write_wdata", wdata_o, 32'h00000077);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("bp_write_done", 32'(add_o), 32'h0);
        tick();
        chk("bp_idle_busy", 32'(busy_o), 32'h0);
        chk("bp_no_write_rsp", 32'(rsp_valid_o), 32'h0);

        // Async reset while issuing with two queued
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_wdata_i = 32'h00000011;
        tick();
        cmd_wdata_i = 32'h00000022;
        tick();
        cmd_wdata_i = 32'h00000033;
        tick();
        cmd_valid_i = 1'b0;
        chk("ar_pre_add", 32'(add_o), 32'h3);
        chk("ar_pre_count", 32'(fifo_count_o), 32'h2);
        #2;
        preset = 1'b1;
        #1;
        chk("ar_add", 32'(add_o), 32'h0);
        chk("ar_count", 32'(fifo_count_o), 32'h0);
        chk("ar_busy", 32'(busy_o), 32'h0);
        chk("ar_wdata", wdata_o, 32'h0);
        chk("ar_rsp_data", rsp_data_o, 32'h0);
        tick();
        preset = 1'b0;
        ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("ar_post%0d_add", c), 32'(add_o), 32'h0);
            chk($sformatf("ar_post%0d_rsp", c), 32'(rsp_valid_o), 32'h0);
            chk($sformatf("ar_post%0d_count", c), 32'(fifo_count_o), 32'h0);
        end
        ready_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
